// File: rtl/selector_pkg.sv
// Shared execute-stage selector encodings: ALU operand sources and the
// HI/LO multiply/divide operation select.
package selector;

    typedef enum logic [1:0] {
        ALU_SRC_A_RS,
        ALU_SRC_A_PC,
        ALU_SRC_A_SHAMT
    } alu_src_a_e;

    typedef enum logic [1:0] {
        ALU_SRC_B_RT,
        ALU_SRC_B_IMM_SEXT,
        ALU_SRC_B_IMM_ZEXT
    } alu_src_b_e;

    typedef enum logic [2:0] {
        MULDIV_MULT,
        MULDIV_MULTU,
        MULDIV_DIV,
        MULDIV_DIVU,
        MULDIV_MTHI,
        MULDIV_MTLO,
        MULDIV_NONE
    } muldiv_op;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_iter.sv
// One unsigned restoring-divide step: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_iter (
    input  logic [31:0] rem_in,
    input  logic [31:0] quo_in,
    input  logic [31:0] divisor,
    output logic [31:0] rem_out,
    output logic [31:0] quo_out
);

    logic [32:0] shifted;
    logic        take;

    always_comb begin
        shifted = {rem_in, quo_in[31]};
        take    = (shifted >= {1'b0, divisor});
        rem_out = take ? (shifted[31:0] - divisor) : shifted[31:0];
        quo_out = {quo_in[30:0], take};
    end

endmodule

// File: rtl/muldiv_unit.sv
// Execute-stage HI/LO unit: single-cycle multiply, 32-iteration restoring
// divide with a sign-fixup cycle, and MTHI/MTLO writes.
module muldiv_unit
    import selector::*;
#(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  muldiv_op    op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    if (DIV_ITERS != 32) begin : g_bad_iters
        $error("muldiv_unit: DIV_ITERS must be 32 for a 32-bit datapath");
    end

    localparam logic [4:0] LAST_ITER = 5'(DIV_ITERS - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

    state_e      state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        done_q, done_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] rem_q, rem_d, quo_q, quo_d;
    logic        mul_signed_q, mul_signed_d;
    logic        quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;

    logic        div_signed;
    logic        a_ext, b_ext;
    logic [63:0] product;
    logic [31:0] rem_next, quo_next;

    assign div_signed = (op == MULDIV_DIV);
    assign a_ext      = mul_signed_q & a_q[31];
    assign b_ext      = mul_signed_q & b_q[31];
    assign product    = {{32{a_ext}}, a_q} * {{32{b_ext}}, b_q};

    div_iter u_div_iter (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (b_q),
        .rem_out (rem_next),
        .quo_out (quo_next)
    );

    // For DIV/DIVU, b holds the divisor magnitude and quo starts as the
    // dividend magnitude; a keeps the raw dividend for the divide-by-zero result.
    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        done_d       = 1'b0;
        count_d      = count_q;
        a_d          = a_q;
        b_d          = b_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        mul_signed_d = mul_signed_q;
        quo_neg_d    = quo_neg_q;
        rem_neg_d    = rem_neg_q;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    case (op)
                        MULDIV_MTHI: hi_d = rs;
                        MULDIV_MTLO: lo_d = rs;
                        MULDIV_MULT, MULDIV_MULTU: begin
                            a_d          = rs;
                            b_d          = rt;
                            mul_signed_d = (op == MULDIV_MULT);
                            state_d      = MUL;
                        end
                        MULDIV_DIV, MULDIV_DIVU: begin
                            a_d       = rs;
                            b_d       = div_signed ? abs32(rt) : rt;
                            quo_d     = div_signed ? abs32(rs) : rs;
                            rem_d     = 32'd0;
                            quo_neg_d = div_signed & (rs[31] ^ rt[31]);
                            rem_neg_d = div_signed & rs[31];
                            count_d   = 5'd0;
                            state_d   = DIV;
                        end
                        default: ;
                    endcase
                end
            end
            MUL: begin
                state_d = IDLE;
                if (!flush) begin
                    {hi_d, lo_d} = product;
                    done_d       = 1'b1;
                end
            end
            DIV: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    rem_d   = rem_next;
                    quo_d   = quo_next;
                    count_d = count_q + 5'd1;
                    if (count_q == LAST_ITER) state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (b_q == 32'd0) begin
                        lo_d = 32'hFFFF_FFFF;
                        hi_d = a_q;
                    end else begin
                        lo_d = quo_neg_q ? (~quo_q + 32'd1) : quo_q;
                        hi_d = rem_neg_q ? (~rem_q + 32'd1) : rem_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
            done_q       <= 1'b0;
            count_q      <= 5'd0;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            rem_q        <= 32'd0;
            quo_q        <= 32'd0;
            mul_signed_q <= 1'b0;
            quo_neg_q    <= 1'b0;
            rem_neg_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            done_q       <= done_d;
            count_q      <= count_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            mul_signed_q <= mul_signed_d;
            quo_neg_q    <= quo_neg_d;
            rem_neg_q    <= rem_neg_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
